// File: rtl/aes_pkg.sv
// Shared helpers for the AES inverse cipher: FSM encoding, inverse S-box, GF(2^8) arithmetic,
// InvShiftRows and InvMixColumns. Byte 0 of a 128-bit block sits at [127:120], column-major.
package aes_pkg;

  localparam int unsigned AES256_ROUNDS = 14;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} eng_state_e;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x9, 0xB, 0xD, 0xE cover InvMixColumns).
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_round_datapath.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// InvMixColumns is skipped for the final round.
module inv_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] shifted, subbed, keyed, mixed;

  always_comb begin
    shifted = inv_shift_rows(state_in);
    subbed  = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
    end
    keyed = subbed ^ round_key;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
    end
    state_out = last_round ? keyed : mixed;
  end

endmodule

// File: rtl/aes_decrypt_round_engine.sv
// Iterative AES inverse cipher, one round per clock, keys fetched by index from an external store.
// Define AES_DEC_ABORT_EN to add an abort input that drops the block in flight.
module aes_decrypt_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES256_ROUNDS,
  parameter int unsigned KEY_IDX_W  = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
`ifdef AES_DEC_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data
);

  eng_state_e           fsm_q;
  logic [KEY_IDX_W-1:0] rnd_q;
  logic [127:0]         state_q;
  logic [127:0]         dp_out;
  logic                 last_round;
  logic                 abort_req;

`ifdef AES_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_ready   = (fsm_q == StIdle);
  assign last_round = (fsm_q == StFinal);

  // Depends only on registered state so the key store cannot close a loop through in_valid.
  always_comb begin
    unique case (fsm_q)
      StRound: key_idx = rnd_q;
      StFinal: key_idx = '0;
      default: key_idx = KEY_IDX_W'(NUM_ROUNDS);
    endcase
  end

  inv_round_datapath u_inv_round_datapath (
    .state_in  (state_q),
    .round_key (round_key),
    .last_round(last_round),
    .state_out (dp_out)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fsm_q     <= StIdle;
      rnd_q     <= '0;
      state_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort_req && (fsm_q != StIdle)) begin
      fsm_q     <= StIdle;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= in_data ^ round_key;
            rnd_q   <= KEY_IDX_W'(NUM_ROUNDS - 1);
            fsm_q   <= StRound;
          end
        end
        StRound: begin
          state_q <= dp_out;
          rnd_q   <= rnd_q - 1'b1;
          if (rnd_q == KEY_IDX_W'(1)) fsm_q <= StFinal;
        end
        StFinal: begin
          out_data  <= dp_out;
          out_valid <= 1'b1;
          fsm_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_q     <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule
